// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_pkg;

    localparam int unsigned PC_WIDTH_DEF        = 8;
    localparam int unsigned PC_RESET_VECTOR_DEF = 0;

    // Next-PC source, listed lowest to highest priority after hold
    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_BR   = 3'd2,
        PC_LOAD = 3'd3,
        PC_CALL = 3'd4,
        PC_RET  = 3'd5
    } pc_src_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/status bundle between the fetch control and the PC sequencer.
interface pc_sequencer_if
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH_DEF,
    parameter int unsigned OFF_W = 8,
    parameter int unsigned HIST  = 2
);
    logic                    Enable_PC;
    logic                    Update_PC;
    logic [WIDTH-1:0]        New_Address;
    logic                    Branch_PC;
    logic [OFF_W-1:0]        Offset;
    logic                    Call_PC;
    logic                    Ret_PC;
    logic                    Stall;
    logic                    Flush;
    logic [WIDTH-1:0]        PC;
    logic [HIST*WIDTH-1:0]   PC_Hist;
    logic [HIST-1:0]         Hist_Valid;
    logic                    Ras_Err;

    modport master (
        output Enable_PC, Update_PC, New_Address, Branch_PC, Offset,
               Call_PC, Ret_PC, Stall, Flush,
        input  PC, PC_Hist, Hist_Valid, Ras_Err
    );

    modport slave (
        input  Enable_PC, Update_PC, New_Address, Branch_PC, Offset,
               Call_PC, Ret_PC, Stall, Flush,
        output PC, PC_Hist, Hist_Valid, Ras_Err
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest
// entry, a pop when empty changes nothing; both raise a one-cycle error.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH_DEF,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_c,
    output logic             empty_c,
    output logic             err_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             wr_en;

    // Pointer/count update; pop takes precedence if both are requested
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        wr_en = 1'b0;
        if (pop_i) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                ptr_d = ptr_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (push_i) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + PTR_W'(1);
            if (cnt_q == CNT_W'(DEPTH)) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Control state; reset empties the stack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Entry storage; contents are only meaningful below the count
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

    assign top_c   = mem_q[ptr_q - PTR_W'(1)];
    assign empty_c = (cnt_q == '0);
    assign err_o   = err_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with PC history and optional return-address
// stack (enabled by defining PC_RAS_EN).
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH        = PC_WIDTH_DEF,
    parameter int unsigned STEP         = 1,
    parameter int unsigned OFF_W        = 8,
    parameter int unsigned HIST         = 2,
    parameter int unsigned RAS_DEPTH    = 4,
    parameter int unsigned RESET_VECTOR = PC_RESET_VECTOR_DEF
) (
    input  logic           clk,
    input  logic           Reset,
    pc_sequencer_if.slave  bus
);
    logic [WIDTH-1:0]      pc_q, pc_d;
    logic [HIST*WIDTH-1:0] hist_q, hist_d;
    logic [HIST-1:0]       hv_q, hv_d;
    pc_src_e               src_c;
    logic [WIDTH-1:0]      inc_c, br_c;
    logic [WIDTH-1:0]      ras_top_c;
    logic                  ras_empty_c;
    logic                  ras_err;

    assign inc_c = pc_q + WIDTH'(STEP);
    assign br_c  = pc_q + WIDTH'($signed(bus.Offset));

`ifdef PC_RAS_EN
    // Call/return storage
    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (Reset),
        .push_i      (src_c == PC_CALL),
        .pop_i       (src_c == PC_RET),
        .push_data_i (inc_c),
        .top_c       (ras_top_c),
        .empty_c     (ras_empty_c),
        .err_o       (ras_err)
    );
`else
    logic unused_ret;
    assign unused_ret  = bus.Ret_PC;
    assign ras_top_c   = '0;
    assign ras_empty_c = 1'b1;
    assign ras_err     = 1'b0;
`endif

    // Request priority: stall, return, call, load, branch, increment
    always_comb begin
        src_c = PC_HOLD;
        if (bus.Stall) begin
            src_c = PC_HOLD;
`ifdef PC_RAS_EN
        end else if (bus.Ret_PC) begin
            src_c = PC_RET;
        end else if (bus.Call_PC) begin
            src_c = PC_CALL;
`else
        end else if (bus.Call_PC) begin
            src_c = PC_LOAD;
`endif
        end else if (bus.Update_PC) begin
            src_c = PC_LOAD;
        end else if (bus.Branch_PC) begin
            src_c = PC_BR;
        end else if (bus.Enable_PC) begin
            src_c = PC_INC;
        end
    end

    // Next PC and history shift; stall freezes everything
    always_comb begin
        pc_d   = pc_q;
        hist_d = hist_q;
        hv_d   = hv_q;
        case (src_c)
            PC_INC:  pc_d = inc_c;
            PC_BR:   pc_d = br_c;
            PC_LOAD: pc_d = bus.New_Address;
            PC_CALL: pc_d = bus.New_Address;
            PC_RET:  pc_d = ras_empty_c ? pc_q : ras_top_c;
            default: pc_d = pc_q;
        endcase
        if (!bus.Stall) begin
            hist_d[0 +: WIDTH] = pc_q;
            hv_d[0]            = 1'b1;
            for (int k = 1; k < int'(HIST); k++) begin
                hist_d[k*WIDTH +: WIDTH] = hist_q[(k-1)*WIDTH +: WIDTH];
                hv_d[k]                  = hv_q[k-1];
            end
            if (bus.Flush) begin
                hv_d = '0;
            end
        end
    end

    // PC and history registers
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            pc_q   <= WIDTH'(RESET_VECTOR);
            hist_q <= '0;
            hv_q   <= '0;
        end else begin
            pc_q   <= pc_d;
            hist_q <= hist_d;
            hv_q   <= hv_d;
        end
    end

    assign bus.PC         = pc_q;
    assign bus.PC_Hist    = hist_q;
    assign bus.Hist_Valid = hv_q;
    assign bus.Ras_Err    = ras_err;

endmodule
